// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants for the LIF array scheduler
package lif_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] PAT_BASE    = 3'b000;
  localparam logic [2:0] PAT_EXCITE  = 3'b001;
  localparam logic [2:0] PAT_INHIBIT = 3'b010;

  localparam logic [7:0] DEF_THRESHOLD       = 8'd200;
  localparam logic [7:0] DEF_RESET_POTENTIAL = 8'd50;
  localparam logic [7:0] DEF_LEAK_RATE       = 8'd5;
  localparam logic [7:0] DEF_COUPLING_WEIGHT = 8'd20;

endpackage

// File: rtl/lif_update_core.sv
// rtl/lif_update_core.sv - combinational single-neuron LIF update, shared by all neurons
module lif_update_core
  import lif_pkg::*;
#(
  parameter logic [7:0] THRESHOLD       = DEF_THRESHOLD,
  parameter logic [7:0] RESET_POTENTIAL = DEF_RESET_POTENTIAL,
  parameter logic [7:0] LEAK_RATE       = DEF_LEAK_RATE
) (
  input  logic [7:0] p_i,
  input  logic [4:0] base_i,
  input  logic [2:0] pattern_i,
  input  logic [7:0] coupling_i,
  output logic [7:0] p_next_o,
  output logic       spike_o
);

  logic [7:0] base_ext;
  logic [7:0] drive;

  assign base_ext = {3'b000, base_i};
  assign spike_o  = (p_i >= THRESHOLD);

  // All arithmetic is modulo 256; inhibition below zero wraps on purpose
  always_comb begin
    case (pattern_i)
      PAT_EXCITE:  drive = base_ext + coupling_i;
      PAT_INHIBIT: drive = base_ext - coupling_i;
      default:     drive = base_ext;
    endcase
  end

  always_comb begin
    if (spike_o) begin
      p_next_o = RESET_POTENTIAL;
    end else if (p_i > LEAK_RATE) begin
      p_next_o = p_i + drive - LEAK_RATE;
    end else begin
      p_next_o = p_i + drive;
    end
  end

endmodule

// File: rtl/lif_array_scheduler.sv
// rtl/lif_array_scheduler.sv - sweeps N virtual LIF neurons through one shared update core
// Optional spike event FIFO enabled by defining LIF_SCHED_EVT_FIFO_EN.
module lif_array_scheduler
  import lif_pkg::*;
#(
  parameter int         N_NEURONS       = 4,
  parameter int         IDX_W           = 2,
  parameter logic [7:0] THRESHOLD       = DEF_THRESHOLD,
  parameter logic [7:0] RESET_POTENTIAL = DEF_RESET_POTENTIAL,
  parameter logic [7:0] LEAK_RATE       = DEF_LEAK_RATE,
  parameter logic [7:0] COUPLING_WEIGHT = DEF_COUPLING_WEIGHT,
  parameter int         EVT_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 step_req,
  output logic                 step_busy,
  output logic                 step_done,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [4:0]           cfg_current,
  input  logic [2:0]           cfg_pattern,
  input  logic [IDX_W-1:0]     mon_addr,
  output logic [7:0]           mon_potential,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 evt_valid,
  output logic [IDX_W-1:0]     evt_idx,
  input  logic                 evt_ready,
  output logic                 evt_overflow
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           pot_q [N_NEURONS];
  logic [4:0]           cur_q [N_NEURONS];
  logic [2:0]           pat_q [N_NEURONS];
  logic [N_NEURONS-1:0] spike_vec_q;
  logic [N_NEURONS-1:0] shadow_q;

  logic [IDX_W-1:0] prev_idx;
  logic [7:0]       coupling;
  logic [7:0]       core_p_next;
  logic             core_spike;
  logic             sweep_fire;

  // Coupling reads the committed vector, so every neuron sees the previous step's spikes
  assign prev_idx   = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
  assign coupling   = spike_vec_q[prev_idx] ? COUPLING_WEIGHT : 8'd0;
  assign sweep_fire = ena && (state_q == ST_SWEEP) && core_spike;

  lif_update_core #(
    .THRESHOLD      (THRESHOLD),
    .RESET_POTENTIAL(RESET_POTENTIAL),
    .LEAK_RATE      (LEAK_RATE)
  ) u_core (
    .p_i       (pot_q[idx_q]),
    .base_i    (cur_q[idx_q]),
    .pattern_i (pat_q[idx_q]),
    .coupling_i(coupling),
    .p_next_o  (core_p_next),
    .spike_o   (core_spike)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (step_req) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (idx_q == IDX_LAST) state_d = ST_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      spike_vec_q <= '0;
      shadow_q    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_q[i] <= RESET_POTENTIAL;
        cur_q[i] <= '0;
        pat_q[i] <= '0;
      end
    end else if (ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Core reads the old entry this cycle, so a write to the swept neuron lands next step
      if (cfg_we && (int'(cfg_addr) < N_NEURONS)) begin
        cur_q[cfg_addr] <= cfg_current;
        pat_q[cfg_addr] <= cfg_pattern;
      end
      case (state_q)
        ST_IDLE:  if (step_req) shadow_q <= '0;
        ST_SWEEP: begin
          pot_q[idx_q]    <= core_p_next;
          shadow_q[idx_q] <= core_spike;
        end
        ST_DONE:  spike_vec_q <= shadow_q;
        default:  ;
      endcase
    end
  end

  assign step_busy = (state_q == ST_SWEEP) || (state_q == ST_DONE);
  assign step_done = ena && (state_q == ST_DONE);
  assign spike_vec = spike_vec_q;

  always_comb begin
    mon_potential = 8'd0;
    if (int'(mon_addr) < N_NEURONS) mon_potential = pot_q[mon_addr];
  end

`ifdef LIF_SCHED_EVT_FIFO_EN
  localparam int PTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int CNT_W = $clog2(EVT_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(EVT_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(EVT_DEPTH);

  logic [IDX_W-1:0] evt_mem_q [EVT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] evt_cnt_q;
  logic             evt_ovf_q;
  logic             evt_pop, evt_full, evt_accept;

  assign evt_full   = (evt_cnt_q == CNT_FULL);
  assign evt_pop    = ena && (evt_cnt_q != '0) && evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push
  assign evt_accept = sweep_fire && (!evt_full || evt_pop);

  always_ff @(posedge clk) begin
    if (evt_accept) evt_mem_q[wr_ptr_q] <= idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      evt_cnt_q <= '0;
      evt_ovf_q <= 1'b0;
    end else begin
      if (evt_accept) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (evt_pop)    rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({evt_accept, evt_pop})
        2'b10:   evt_cnt_q <= evt_cnt_q + 1'b1;
        2'b01:   evt_cnt_q <= evt_cnt_q - 1'b1;
        default: ;
      endcase
      if (sweep_fire && !evt_accept) evt_ovf_q <= 1'b1;
    end
  end

  assign evt_valid    = (evt_cnt_q != '0);
  assign evt_idx      = evt_mem_q[rd_ptr_q];
  assign evt_overflow = evt_ovf_q;
`else
  logic unused_evt;
  assign unused_evt   = evt_ready | (EVT_DEPTH == 0);
  assign evt_valid    = 1'b0;
  assign evt_idx      = '0;
  assign evt_overflow = 1'b0;
`endif

endmodule
